// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier: two multiplier bits retired per cycle,
// signed/unsigned operands, valid/ready handshake on operands and on the result.
module booth_radix4_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [WIDTH-1:0]   in_B,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE; out_valid is high only in DONE and
  // stays high with product stable until out_ready is seen on an edge.

  localparam int EXT   = WIDTH + 2;
  localparam int PPW   = WIDTH + 3;
  localparam int ACCW  = WIDTH + 4;
  localparam int CW    = $clog2(WIDTH / 2 + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [EXT-1:0]      mcand;
  logic [EXT-1:0]      mplier;
  logic                prev;
  logic [ACCW-1:0]     acc;
  logic [CW-1:0]       cnt;

  logic [2:0]          trip;
  logic [PPW-1:0]      m1;
  logic [PPW-1:0]      m2;
  logic [PPW-1:0]      pp;
  logic [ACCW-1:0]     sum;
  logic [ACCW-1:0]     acc_next;
  logic [EXT-1:0]      mplier_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)    state_next = CALC;
      CALC:    if (cnt == LAST) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Booth digit select on {B[2i+1], B[2i], B[2i-1]}; prev holds B[2i-1].
  assign trip = {mplier[1:0], prev};
  assign m1   = {mcand[EXT-1], mcand};
  assign m2   = {mcand, 1'b0};

  always_comb begin
    pp = '0;
    case (trip)
      3'b001, 3'b010: pp = m1;
      3'b011:         pp = m2;
      3'b100:         pp = ~m2 + PPW'(1);
      3'b101, 3'b110: pp = ~m1 + PPW'(1);
      default:        pp = '0;
    endcase
  end

  // Add into the high half, then shift {acc, mplier} right by 2 arithmetically;
  // low product bits migrate into mplier as its bits are consumed.
  assign sum         = acc + {{(ACCW - PPW){pp[PPW-1]}}, pp};
  assign acc_next    = {{2{sum[ACCW-1]}}, sum[ACCW-1:2]};
  assign mplier_next = {sum[1:0], mplier[EXT-1:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      prev    <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= signed_mode ? {{2{in_A[WIDTH-1]}}, in_A} : {2'b00, in_A};
            mplier <= signed_mode ? {{2{in_B[WIDTH-1]}}, in_B} : {2'b00, in_B};
            prev   <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          prev   <= mplier[1];
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) product <= {acc_next[WIDTH-3:0], mplier_next};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/booth_radix4_multiplier.md
Name: booth_radix4_multiplier

Overview:
Parametrised sequential radix-4 Booth multiplier with signed/unsigned mode select and valid/ready handshakes on both the operand and result sides. It retires two multiplier bits per cycle, so a WIDTH x WIDTH multiply completes in WIDTH/2+1 cycles. It is the next-generation drop-in for the 16-bit radix-2 datapath/controller multiplier. Sequencing is internal, so no external load strobes are needed.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 4; product is 2*WIDTH bits.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand handshake valid
in_ready  output  1  block can accept operands; high only in IDLE
in_A  input  WIDTH  multiplicand
in_B  input  WIDTH  multiplier
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
out_valid  output  1  product valid; held until accepted
out_ready  input  1  result handshake ready
product  output  2*WIDTH  result register
busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, named reset.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, iteration counter=0, accumulator=0.
- Reset has priority over every other event, including mid-CALC and while DONE is stalled.
- After a reset edge the block is in IDLE; any in-flight result is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch in_A, in_B and signed_mode.
  - Extend both operands to WIDTH+2 bits: sign-extend if signed_mode=1, else zero-extend.
  - Clear the accumulator and counter, then go to CALC.
  - With in_valid=0, remain in IDLE.
- CALC:
  - One Booth step per edge.
  - Examine the triplet {B[2i+1], B[2i], B[2i-1]}, with B[-1]=0.
  - Select 0, +M, +2M, -M or -2M. Use WIDTH+3-bit partial products, computing -M by two's complement.
  - Add the selection into the accumulator, arithmetic-shifting by 2 per step.
  - Counter runs 0..WIDTH/2. After step WIDTH/2 (WIDTH/2+1 steps total), write the lower 2*WIDTH bits into product and go to DONE.
- DONE:
  - out_valid=1; product stable.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - product retains its value after acceptance until the next result is written.
- Latency: exactly WIDTH/2+1 rising edges from the accepting edge (in_valid & in_ready) to the first cycle with out_valid=1. This is 9 for WIDTH=16. Latency is independent of operand values and mode.
- Throughput: one operation per WIDTH/2+3 cycles minimum. in_ready is low in CALC and DONE, so the next operand is accepted only in IDLE.
- Operand inputs and in_valid are ignored outside IDLE. Operand changes during CALC do not affect the result.
- out_ready is ignored outside DONE.
- Arithmetic: the result is exact for all operand pairs in both modes.
  - Unsigned range: 0..(2^WIDTH-1)^2.
  - Signed range: includes (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) with no overflow.
- Zero operand: the full WIDTH/2+1 cycles still elapse; product=0.
- Stall: out_ready=0 indefinitely holds DONE with out_valid=1 and product unchanged.

Test Plan:
- Reset: assert reset for 2 edges with in_valid=1 -> product=0, out_valid=0, busy=0, in_ready=1 after the reset edge; nothing accepted during reset.
- Unsigned max (WIDTH=16): in_A=0xFFFF, in_B=0xFFFF, signed_mode=0, out_ready=1 -> out_valid rises exactly 9 edges after accept; product=0xFFFE0001; in_ready returns to 1 one edge later.
- Signed corners: A=0x8000, B=0x8000, signed_mode=1 -> 0x40000000. A=0xFFFF, B=0x0003, signed_mode=1 -> 0xFFFFFFFD. Same operands with signed_mode=0 -> 0x0002FFFD.
- Backpressure: complete A=0x1234, B=0x5678 unsigned with out_ready=0 for 6 cycles and in_valid pulsed with new operands -> out_valid held, product=0x06260060 stable, in_ready=0, pulses ignored; accepted on the first out_ready=1 edge.
- Reset mid-operation: assert reset on the 4th CALC edge -> IDLE next cycle, out_valid never asserts. Following op A=0x0007, B=0xFFF9, signed_mode=1 -> product=0xFFFFFFCF.
- WIDTH=8 instance: 300 random ops, both modes, random out_ready -> every product matches the reference model; latency is 5 on every op.
